// File: rtl/rtype_exec.sv
// RV32 R-type executor: 4-cycle IDLE/DECODE/EXEC/WB FSM with a 32x32 register file.
// Optional M-extension multiplies: define RTYPE_EXEC_MEXT_EN.
module rtype_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  input  logic            dbg_we,
  input  logic [4:0]      dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] res,
  output logic [4:0]      wrt,
  output logic            done,
  output logic            illegal
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [31:0]     instr_q;
  logic [XLEN-1:0] op1_q, op2_q, res_q;
  logic [4:0]      wrt_q;
  logic            done_q, illegal_q;
  logic [XLEN-1:0] rf_q [32];

  logic [6:0]      f7;
  logic [2:0]      f3;
  logic [4:0]      rs1, rs2, shamt;
  logic            legal;
  logic [XLEN-1:0] rs1_v, rs2_v, alu;

  assign f7    = instr_q[31:25];
  assign f3    = instr_q[14:12];
  assign rs1   = instr_q[19:15];
  assign rs2   = instr_q[24:20];
  assign shamt = op2_q[4:0];

  assign rs1_v = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_v = (rs2 == 5'd0) ? '0 : rf_q[rs2];

`ifdef RTYPE_EXEC_MEXT_EN
  logic [2*XLEN-1:0] a_s, a_u, b_s, b_u;
  logic [2*XLEN-1:0] mul_ss, mul_su, mul_uu;

  assign a_s = {{XLEN{op1_q[XLEN-1]}}, op1_q};
  assign a_u = {{XLEN{1'b0}}, op1_q};
  assign b_s = {{XLEN{op2_q[XLEN-1]}}, op2_q};
  assign b_u = {{XLEN{1'b0}}, op2_q};

  // Modular 2*XLEN products of extended operands give every high half.
  assign mul_ss = a_s * b_s;
  assign mul_su = a_s * b_u;
  assign mul_uu = a_u * b_u;
`endif

  // Legality of the latched encoding, evaluated while in DECODE.
  always_comb begin
    legal = 1'b0;
    if (instr_q[6:0] == 7'b0110011) begin
      unique case (1'b1)
        (f7 == 7'b0000000): legal = 1'b1;
        (f7 == 7'b0100000): legal = (f3 == 3'b000) || (f3 == 3'b101);
`ifdef RTYPE_EXEC_MEXT_EN
        (f7 == 7'b0000001): legal = ~f3[2];
`endif
        default:            legal = 1'b0;
      endcase
    end
  end

  // ALU result from the registered operands.
  always_comb begin
    alu = '0;
    unique case ({f7, f3})
      10'b0000000_000: alu = op1_q + op2_q;
      10'b0100000_000: alu = op1_q - op2_q;
      10'b0000000_001: alu = op1_q << shamt;
      10'b0000000_010: alu = {{(XLEN-1){1'b0}},
                              $signed(op1_q) < $signed(op2_q)};
      10'b0000000_011: alu = {{(XLEN-1){1'b0}}, op1_q < op2_q};
      10'b0000000_100: alu = op1_q ^ op2_q;
      10'b0000000_101: alu = op1_q >> shamt;
      10'b0100000_101: alu = $unsigned($signed(op1_q) >>> shamt);
      10'b0000000_110: alu = op1_q | op2_q;
      10'b0000000_111: alu = op1_q & op2_q;
`ifdef RTYPE_EXEC_MEXT_EN
      10'b0000001_000: alu = mul_ss[XLEN-1:0];
      10'b0000001_001: alu = mul_ss[2*XLEN-1:XLEN];
      10'b0000001_010: alu = mul_su[2*XLEN-1:XLEN];
      10'b0000001_011: alu = mul_uu[2*XLEN-1:XLEN];
`endif
      default:         alu = '0;
    endcase
  end

  // Next-state logic; rejected encodings drop straight back to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (instr_valid) state_d = DECODE;
      DECODE:  state_d = legal ? EXEC : IDLE;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, instruction latch, operand/result registers and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      res_q     <= '0;
      wrt_q     <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= (state_q == WB);
      illegal_q <= (state_q == DECODE) && !legal;
      if (state_q == IDLE && instr_valid) begin
        instr_q <= instr;
      end
      if (state_q == DECODE && legal) begin
        op1_q <= rs1_v;
        op2_q <= rs2_v;
        wrt_q <= instr_q[11:7];
      end
      if (state_q == EXEC) begin
        res_q <= alu;
      end
    end
  end

  // Register file: debug preload only in IDLE, writeback in WB, x0 stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (state_q == WB) begin
      if (wrt_q != 5'd0) rf_q[wrt_q] <= res_q;
    end else if (state_q == IDLE && dbg_we) begin
      if (dbg_addr != 5'd0) rf_q[dbg_addr] <= dbg_wdata;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign op1         = op1_q;
  assign op2         = op2_q;
  assign res         = res_q;
  assign wrt         = wrt_q;
  assign done        = done_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_rtype_exec.sv
// Directed testbench for rtype_exec.
// Register contents are observed through ADD x0,xN,x0 reads of op1.
module tb_rtype_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic        dbg_we = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic [31:0] op1, op2, res;
  logic [4:0]  wrt;
  logic        done, illegal;

  int checks = 0;
  int errors = 0;

  rtype_exec #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata),
    .op1(op1), .op2(op2), .res(res), .wrt(wrt),
    .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(
    input logic [6:0] f7, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    tick();
    dbg_we = 1'b0;
  endtask

  // Accept at edge k and run through edge k+3.
  task automatic run_instr(input logic [31:0] iw);
    instr_valid = 1'b1; instr = iw;
    tick();
    instr_valid = 1'b0;
    tick(); tick(); tick();
  endtask

  // Read RF[r] via op1 of ADD x0,r,x0, leaving the FSM back in IDLE.
  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    instr_valid = 1'b1; instr = enc(7'h00, 5'd0, r, 3'b000, 5'd0);
    tick();
    instr_valid = 1'b0;
    tick();
    v = op1;
    tick(); tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b exp 1", instr_ready);
    end
    checks++;
    if ({op1, op2, res} !== 96'd0) begin
      errors++; $display("FAIL reset_ops got %h %h %h exp 0", op1, op2, res);
    end
    checks++;
    if ({wrt, done, illegal} !== 7'd0) begin
      errors++; $display("FAIL reset_ctl got %h %b %b exp 0", wrt, done, illegal);
    end
  endtask

  task automatic test_add();
    logic [31:0] v;
    dbg_write(5'd1, 32'd5);
    dbg_write(5'd2, 32'd7);
    instr_valid = 1'b1; instr = 32'h002081B3;
    tick();
    instr_valid = 1'b0;
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++; $display("FAIL add_busy got %b exp 0", instr_ready);
    end
    tick();
    checks++;
    if (op1 !== 32'd5 || op2 !== 32'd7 || wrt !== 5'd3) begin
      errors++; $display("FAIL add_ops got %h %h %0d exp 5 7 3", op1, op2, wrt);
    end
    tick();
    checks++;
    if (res !== 32'd12 || done !== 1'b0) begin
      errors++; $display("FAIL add_res got %h done %b exp 12 0", res, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || instr_ready !== 1'b1) begin
      errors++; $display("FAIL add_done got %b rdy %b exp 1 1", done, instr_ready);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL add_done_pulse got %b exp 0", done);
    end
    read_reg(5'd3, v);
    checks++;
    if (v !== 32'd12) begin
      errors++; $display("FAIL add_x3 got %h exp 12", v);
    end
  endtask

  task automatic test_shifts();
    dbg_write(5'd1, 32'h8000_0000);
    dbg_write(5'd2, 32'd1);
    run_instr(enc(7'h20, 5'd2, 5'd1, 3'b101, 5'd4));
    checks++;
    if (res !== 32'hC000_0000) begin
      errors++; $display("FAIL sra got %h exp c0000000", res);
    end
    run_instr(enc(7'h00, 5'd2, 5'd1, 3'b101, 5'd4));
    checks++;
    if (res !== 32'h4000_0000) begin
      errors++; $display("FAIL srl got %h exp 40000000", res);
    end
    run_instr(enc(7'h00, 5'd2, 5'd1, 3'b010, 5'd5));
    checks++;
    if (res !== 32'd1) begin
      errors++; $display("FAIL slt got %h exp 1", res);
    end
    run_instr(enc(7'h00, 5'd2, 5'd1, 3'b011, 5'd5));
    checks++;
    if (res !== 32'd0) begin
      errors++; $display("FAIL sltu got %h exp 0", res);
    end
    run_instr(enc(7'h00, 5'd2, 5'd1, 3'b001, 5'd5));
    checks++;
    if (res !== 32'd0) begin
      errors++; $display("FAIL sll got %h exp 0", res);
    end
    dbg_write(5'd1, 32'h0000_00F0);
    dbg_write(5'd2, 32'h0000_003C);
    run_instr(enc(7'h00, 5'd2, 5'd1, 3'b100, 5'd5));
    checks++;
    if (res !== 32'h0000_00CC) begin
      errors++; $display("FAIL xor got %h exp cc", res);
    end
    run_instr(enc(7'h00, 5'd2, 5'd1, 3'b110, 5'd5));
    checks++;
    if (res !== 32'h0000_00FC) begin
      errors++; $display("FAIL or got %h exp fc", res);
    end
    run_instr(enc(7'h00, 5'd2, 5'd1, 3'b111, 5'd5));
    checks++;
    if (res !== 32'h0000_0030) begin
      errors++; $display("FAIL and got %h exp 30", res);
    end
  endtask

  task automatic test_x0();
    logic [31:0] v;
    dbg_write(5'd1, 32'd5);
    dbg_write(5'd2, 32'd1);
    run_instr(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd0));
    checks++;
    if (done !== 1'b1 || res !== 32'd6) begin
      errors++; $display("FAIL x0_done got %b res %h exp 1 6", done, res);
    end
    read_reg(5'd0, v);
    checks++;
    if (v !== 32'd0) begin
      errors++; $display("FAIL x0_read got %h exp 0", v);
    end
    run_instr(enc(7'h20, 5'd2, 5'd0, 3'b000, 5'd6));
    checks++;
    if (res !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL sub_wrap got %h exp ffffffff", res);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] v;
    instr_valid = 1'b1; instr = 32'h0000_0013;
    tick();
    instr_valid = 1'b0;
    tick();
    checks++;
    if (illegal !== 1'b1 || instr_ready !== 1'b1) begin
      errors++; $display("FAIL addi_illegal got %b rdy %b exp 1 1", illegal, instr_ready);
    end
    checks++;
    if (res !== 32'hFFFF_FFFF || wrt !== 5'd6) begin
      errors++; $display("FAIL addi_hold got %h %0d exp ffffffff 6", res, wrt);
    end
    tick();
    checks++;
    if (illegal !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL addi_pulse got ill %b done %b exp 0 0", illegal, done);
    end
    read_reg(5'd6, v);
    checks++;
    if (v !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL addi_rf got %h exp ffffffff", v);
    end
    instr_valid = 1'b1; instr = enc(7'h20, 5'd2, 5'd1, 3'b001, 5'd7);
    tick();
    instr_valid = 1'b0;
    tick();
    checks++;
    if (illegal !== 1'b1) begin
      errors++; $display("FAIL f7_illegal got %b exp 1", illegal);
    end
    tick(); tick();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL f7_nodone got %b exp 0", done);
    end
    read_reg(5'd7, v);
    checks++;
    if (v !== 32'd0) begin
      errors++; $display("FAIL f7_rf got %h exp 0", v);
    end
  endtask

  task automatic test_dbg_ignored();
    logic [31:0] v;
    instr_valid = 1'b1; instr = enc(7'h00, 5'd0, 5'd0, 3'b000, 5'd0);
    tick();
    instr_valid = 1'b0;
    dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'hDEAD_BEEF;
    tick(); tick(); tick();
    dbg_we = 1'b0;
    read_reg(5'd9, v);
    checks++;
    if (v !== 32'd0) begin
      errors++; $display("FAIL dbg_busy got %h exp 0", v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    int n;
    do_reset();
    dbg_write(5'd1, 32'd5);
    dbg_write(5'd2, 32'd7);
    instr_valid = 1'b1; instr = 32'h002081B3;
    tick();
    instr = enc(7'h00, 5'd3, 5'd3, 3'b000, 5'd4);
    n = 0;
    while (instr_ready !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL b2b_gap got %0d exp 3", n);
    end
    tick();
    instr_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (res !== 32'd24 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_res got %h done %b exp 24 1", res, done);
    end
    read_reg(5'd4, v);
    checks++;
    if (v !== 32'd24) begin
      errors++; $display("FAIL b2b_x4 got %h exp 24", v);
    end
  endtask

  task automatic test_reset_exec();
    logic [31:0] v;
    do_reset();
    dbg_write(5'd1, 32'd5);
    dbg_write(5'd2, 32'd7);
    instr_valid = 1'b1; instr = 32'h002081B3;
    tick();
    instr_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({op1, op2, res, wrt, done, illegal} !== 103'd0) begin
      errors++; $display("FAIL rst_exec got %h %h %h %0d %b exp 0", op1, op2, res, wrt, done);
    end
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL rst_exec_ready got %b exp 1", instr_ready);
    end
    tick(); tick();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL rst_exec_done got %b exp 0", done);
    end
    read_reg(5'd3, v);
    checks++;
    if (v !== 32'd0) begin
      errors++; $display("FAIL rst_exec_x3 got %h exp 0", v);
    end
  endtask

  task automatic test_mext();
    dbg_write(5'd1, 32'hFFFF_FFFF);
    dbg_write(5'd2, 32'hFFFF_FFFF);
`ifdef RTYPE_EXEC_MEXT_EN
    run_instr(enc(7'h01, 5'd2, 5'd1, 3'b011, 5'd8));
    checks++;
    if (res !== 32'hFFFF_FFFE || done !== 1'b1) begin
      errors++; $display("FAIL mulhu got %h done %b exp fffffffe 1", res, done);
    end
    run_instr(enc(7'h01, 5'd2, 5'd1, 3'b001, 5'd8));
    checks++;
    if (res !== 32'd0) begin
      errors++; $display("FAIL mulh got %h exp 0", res);
    end
    run_instr(enc(7'h01, 5'd2, 5'd1, 3'b000, 5'd8));
    checks++;
    if (res !== 32'd1) begin
      errors++; $display("FAIL mul got %h exp 1", res);
    end
    run_instr(enc(7'h01, 5'd2, 5'd1, 3'b010, 5'd8));
    checks++;
    if (res !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL mulhsu got %h exp ffffffff", res);
    end
`else
    instr_valid = 1'b1; instr = enc(7'h01, 5'd2, 5'd1, 3'b011, 5'd8);
    tick();
    instr_valid = 1'b0;
    tick();
    checks++;
    if (illegal !== 1'b1) begin
      errors++; $display("FAIL mulhu_illegal got %b exp 1", illegal);
    end
    tick(); tick();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL mulhu_nodone got %b exp 0", done);
    end
`endif
  endtask

  initial begin
    tick();
    test_reset();
    test_add();
    test_shifts();
    test_x0();
    test_illegal();
    test_dbg_ignored();
    test_back_to_back();
    test_reset_exec();
    test_mext();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtype_exec.md
RTYPE_EXEC -- requirements
Module: rtype_exec

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data width of registers and operands; the only supported value is 32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port instr_valid, input, 1, upstream instruction word present.
REQ-005 The block SHALL have port instr, input, 32, RV32 instruction word.
REQ-006 The block SHALL have port instr_ready, output, 1, block can accept an instruction.
REQ-007 The block SHALL have ports dbg_we (input, 1), dbg_addr (input, 5) and dbg_wdata (input, 32), forming a register-file preload write port.
REQ-008 The block SHALL have ports op1 and op2, output, 32 each, the registered rs1 and rs2 values.
REQ-009 The block SHALL have port res, output, 32, the registered ALU result.
REQ-010 The block SHALL have port wrt, output, 5, the destination register index of the current or last instruction.
REQ-011 The block SHALL have port done, output, 1, one-cycle pulse on retirement.
REQ-012 The block SHALL have port illegal, output, 1, one-cycle pulse when a non-supported encoding is rejected.

Function
REQ-013 The block SHALL contain a 32 x 32 register file; reads of x0 return 0 and writes to x0 are discarded.
REQ-014 The FSM SHALL have states IDLE, DECODE, EXEC and WB; instr_ready = 1 only in IDLE.
REQ-015 An instruction SHALL be accepted at the edge where instr_valid & instr_ready = 1 (edge k), and the FSM goes IDLE->DECODE; instr is latched and ignored afterwards.
REQ-016 At edge k+1 (DECODE->EXEC), the block SHALL load op1 = RF[instr[19:15]], op2 = RF[instr[24:20]] and wrt = instr[11:7].
REQ-017 At edge k+2 (EXEC->WB), the block SHALL load res per funct7/funct3 with opcode 0110011: ADD, SUB(0100000/000), SLL, SLT (signed), SLTU, XOR, SRL, SRA(0100000/101), OR, AND; shifts use op2[4:0]; results wrap modulo 2^32.
REQ-018 At edge k+3 (WB->IDLE), the block SHALL write RF[wrt] = res and register done = 1 for exactly one cycle.
REQ-019 Throughput SHALL be one instruction per 4 cycles; the earliest next accept is edge k+4, and its DECODE reads observe the k+3 write (no hazard logic).
REQ-020 On an opcode other than 0110011 or an unsupported funct7/funct3, the block SHALL go DECODE->IDLE at edge k+1, pulse illegal for one cycle, perform no RF write, not pulse done, and leave op1/op2/res/wrt unchanged.
REQ-021 A dbg_we write SHALL take effect only at an edge where the state is IDLE; at other edges it is ignored; when it coincides with an accept, the write lands and the accepted instruction's DECODE sees it.
REQ-022 instr_valid deasserted in IDLE SHALL leave all state and outputs unchanged.

Reset
REQ-023 When rst = 1 at an edge, the block SHALL go to IDLE and clear op1, op2, res, wrt, done, illegal and all 32 RF entries to 0.
REQ-024 Reset SHALL take priority over accept and dbg_we; a reset in DECODE/EXEC/WB aborts the instruction with no RF write and no done.
REQ-025 instr_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-026 With macro RTYPE_EXEC_MEXT_EN defined, the block SHALL support funct7 = 0000001 with funct3 000 MUL (low 32), 001 MULH (signed x signed, high 32), 010 MULHSU, 011 MULHU, computed in EXEC with the same latency; funct3 100-111 are illegal.
REQ-027 Without RTYPE_EXEC_MEXT_EN, the block SHALL treat every funct7 = 0000001 encoding as illegal per REQ-020.

Verification
REQ-028 The bench SHALL check: dbg preload x1=5, x2=7; ADD x3,x1,x2 (0x002081B3) -> op1=5, op2=7 at k+1, res=12 at k+2, done at k+3, RF x3=12.
REQ-029 The bench SHALL check: x1=0x80000000, x2=1; SRA x4,x1,x2 -> res=0xC0000000; SRL -> 0x40000000; SLT x5,x1,x2 -> 1; SLTU -> 0.
REQ-030 The bench SHALL check: ADD x0,x1,x2 -> done pulses, x0 reads 0; then SUB x6,x0,x2 with x2=1 -> res=0xFFFFFFFF.
REQ-031 The bench SHALL check: instr=0x00000013 (ADDI) -> illegal pulses at k+1, no done, RF unchanged, instr_ready=1 next cycle.
REQ-032 The bench SHALL check: back-to-back ADD x3,x1,x2 then ADD x4,x3,x3 with instr_valid held high -> accepts 4 cycles apart, x4=24.
REQ-033 The bench SHALL check: rst asserted in EXEC -> next cycle all outputs 0, no done, x3 remains 0; with RTYPE_EXEC_MEXT_EN, MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE, and without it the same encoding -> illegal.
